// File: rtl/serial_sub4.sv
// serial_sub4: bit-serial subtractor computing {bout,diff} = a - b - bin, LSB first,
// using one full-subtractor cell and a borrow flop; one result per WIDTH+2 cycles.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; operands and borrow-in load on accept
//   SHIFT | one difference bit per clock, busy=1, WIDTH cycles
//   DONE  | one-cycle done pulse, diff/bout hold the new result
module serial_sub4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // areg doubles as the result shift register: each consumed minuend bit
    // leaves at the LSB while the matching difference bit enters at the MSB.
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             d_bit;
    logic             brw_nxt;
    logic             last_bit;

    assign d_bit    = areg[0] ^ breg[0] ^ brw;
    assign brw_nxt  = (~areg[0] & breg[0]) | (~(areg[0] ^ breg[0]) & brw);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            areg <= '0;
            breg <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        areg <= a;
                        breg <= b;
                        brw  <= bin;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    areg <= {d_bit, areg[WIDTH-1:1]};
                    breg <= {1'b0, breg[WIDTH-1:1]};
                    brw  <= brw_nxt;
                    cnt  <= cnt + 1'b1;
                    // Outputs only ever see a complete result.
                    if (last_bit) begin
                        diff <= {d_bit, areg[WIDTH-1:1]};
                        bout <= brw_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
